// File: rtl/wash_panel_pkg.sv
// Shared types and defaults for the washing-machine front-panel input stage.
package wash_panel_pkg;

  typedef enum logic [1:0] {
    P_SELECT = 2'd0,
    P_RUN    = 2'd1,
    P_DONE   = 2'd2
  } panel_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DB_CNT_W_DEF        = 8;

endpackage

// File: rtl/wash_panel_ctrl_if.sv
// Panel <-> washing-machine controller signal bundle; master = panel, slave = controller.
// locked_o exists only when PANEL_CHILD_LOCK_EN is defined.
interface wash_panel_ctrl_if;

  logic start_o;
  logic double_wash_o;
  logic dry_wash_o;
  logic time_pause_o;
  logic door_closed_o;
  logic running_o;
  logic reject_o;
  logic done_i;
  logic error_i;
`ifdef PANEL_CHILD_LOCK_EN
  logic locked_o;
`endif

  modport master (
    output start_o, double_wash_o, dry_wash_o, time_pause_o,
    output door_closed_o, running_o, reject_o,
`ifdef PANEL_CHILD_LOCK_EN
    output locked_o,
`endif
    input  done_i, error_i
  );

  modport slave (
    input  start_o, double_wash_o, dry_wash_o, time_pause_o,
    input  door_closed_o, running_o, reject_o,
`ifdef PANEL_CHILD_LOCK_EN
    input  locked_o,
`endif
    output done_i, error_i
  );

endinterface

// File: rtl/wash_panel_debounce.sv
// 2-flop synchroniser + counting debouncer + rising-edge press pulse for one raw contact.
// Debounced level changes 2 + DEBOUNCE_CYCLES edges after a stable raw change.
module wash_panel_debounce #(
  parameter logic RST_LVL         = 1'b0,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   DB_CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  logic                sync1_q;
  logic                sync2_q;
  logic                level_q;
  logic                level_d;
  logic                prev_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_LVL;
      sync2_q <= RST_LVL;
      level_q <= RST_LVL;
      prev_q  <= RST_LVL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs only while the sample disagrees; any agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Front-panel stage feeding the washer controller: debounced buttons, option latches, pause, start level.
// Optional child lock under macro PANEL_CHILD_LOCK_EN (adds locked_o, start acts on short-press release).
module wash_panel_ctrl
  import wash_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int DB_CNT_W         = DB_CNT_W_DEF
`ifdef PANEL_CHILD_LOCK_EN
  , parameter int LOCK_HOLD_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start_raw,
  input  logic              btn_double_raw,
  input  logic              btn_dry_raw,
  input  logic              btn_pause_raw,
  input  logic              door_raw,
  wash_panel_ctrl_if.master ctrl
);

  logic start_lvl,  start_press;
  logic dbl_press,  dry_press, pause_press;
  logic door_lvl;
  logic unused_dbl_lvl, unused_dry_lvl, unused_pause_lvl, unused_door_press;
  logic unused_start;

  wash_panel_debounce #(.RST_LVL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
    u_db_start (.clk(clk), .rst_n(rst_n), .raw_i(btn_start_raw),
                .level_o(start_lvl), .press_o(start_press));

  wash_panel_debounce #(.RST_LVL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
    u_db_double (.clk(clk), .rst_n(rst_n), .raw_i(btn_double_raw),
                 .level_o(unused_dbl_lvl), .press_o(dbl_press));

  wash_panel_debounce #(.RST_LVL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
    u_db_dry (.clk(clk), .rst_n(rst_n), .raw_i(btn_dry_raw),
              .level_o(unused_dry_lvl), .press_o(dry_press));

  wash_panel_debounce #(.RST_LVL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
    u_db_pause (.clk(clk), .rst_n(rst_n), .raw_i(btn_pause_raw),
                .level_o(unused_pause_lvl), .press_o(pause_press));

  // Door idles closed so the controller never sees a spurious open during reset.
  wash_panel_debounce #(.RST_LVL(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W))
    u_db_door (.clk(clk), .rst_n(rst_n), .raw_i(door_raw),
               .level_o(door_lvl), .press_o(unused_door_press));

  logic start_ev, dbl_ev, dry_ev, pause_ev;

`ifdef PANEL_CHILD_LOCK_EN
  localparam int HOLD_W = $clog2(LOCK_HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lock_q, lock_d;
  logic              long_q, long_d;
  logic              start_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      lock_q       <= 1'b0;
      long_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      lock_q       <= lock_d;
      long_q       <= long_d;
      start_prev_q <= start_lvl;
    end
  end

  // A press cannot be classified as short or long until it ends, so start fires on release.
  always_comb begin
    hold_d   = hold_q;
    lock_d   = lock_q;
    long_d   = long_q;
    start_ev = 1'b0;
    if (start_lvl) begin
      if (!long_q) begin
        if (hold_q == HOLD_W'(LOCK_HOLD_CYCLES - 1)) begin
          lock_d = ~lock_q;
          long_d = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end else begin
      hold_d   = '0;
      long_d   = 1'b0;
      start_ev = start_prev_q & ~long_q & ~lock_q;
    end
  end

  assign dbl_ev        = dbl_press & ~lock_q;
  assign dry_ev        = dry_press & ~lock_q;
  assign pause_ev      = pause_press;
  assign unused_start  = start_press;
  assign ctrl.locked_o = lock_q;
`else
  assign start_ev     = start_press;
  assign dbl_ev       = dbl_press;
  assign dry_ev       = dry_press;
  assign pause_ev     = pause_press;
  assign unused_start = start_lvl;
`endif

  panel_state_e state_q, state_d;
  logic         dbl_q,    dbl_d;
  logic         dry_q,    dry_d;
  logic         pause_q,  pause_d;
  logic         reject_q, reject_d;
  logic         done_q;
  logic         done_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= P_SELECT;
      dbl_q    <= 1'b0;
      dry_q    <= 1'b0;
      pause_q  <= 1'b0;
      reject_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dbl_q    <= dbl_d;
      dry_q    <= dry_d;
      pause_q  <= pause_d;
      reject_q <= reject_d;
      done_q   <= ctrl.done_i;
    end
  end

  // done is tracked in every state so a still-high done after re-arming is not an edge.
  assign done_rise = ctrl.done_i & ~done_q;

  always_comb begin
    state_d  = state_q;
    dbl_d    = dbl_q;
    dry_d    = dry_q;
    pause_d  = pause_q;
    reject_d = 1'b0;
    case (state_q)
      P_RUN: begin
        if (done_rise) begin
          state_d = P_DONE;
          pause_d = 1'b0;
        end else if (ctrl.error_i) begin
          pause_d = 1'b0;
        end else if (pause_ev) begin
          pause_d = ~pause_q;
        end
      end
      P_SELECT, P_DONE: begin
        pause_d = 1'b0;
        if (dbl_ev) dbl_d = ~dbl_q;
        if (dry_ev) dry_d = ~dry_q;
        if (start_ev) begin
          if (door_lvl) state_d  = P_RUN;
          else          reject_d = 1'b1;
        end
      end
      default: state_d = P_SELECT;
    endcase
  end

  // Decoding start from the state register lets async reset drop it immediately.
  assign ctrl.start_o       = (state_q == P_RUN);
  assign ctrl.running_o     = (state_q == P_RUN);
  assign ctrl.double_wash_o = dbl_q;
  assign ctrl.dry_wash_o    = dry_q;
  assign ctrl.time_pause_o  = pause_q;
  assign ctrl.reject_o      = reject_q;
  assign ctrl.door_closed_o = door_lvl;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Scoreboard bench for wash_panel_ctrl: stimulus queues expected output vectors with their cycle stamps,
// a monitor pops one entry every time the output vector changes.
module tb_wash_panel_ctrl;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] raw;   // 0 start, 1 double, 2 dry, 3 pause, 4 door
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       q[$];
  logic [6:0] exp_v; // {reject, running, door, pause, dry, double, start}
  logic [6:0] outs;

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  wash_panel_ctrl_if u_if ();

  wash_panel_ctrl #(.DEBOUNCE_CYCLES(4), .DB_CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_raw  (raw[0]),
    .btn_double_raw (raw[1]),
    .btn_dry_raw    (raw[2]),
    .btn_pause_raw  (raw[3]),
    .door_raw       (raw[4]),
    .ctrl           (u_if)
  );

  assign outs = {u_if.reject_o, u_if.running_o, u_if.door_closed_o, u_if.time_pause_o,
                 u_if.dry_wash_o, u_if.double_wash_o, u_if.start_o};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input string nm, input int dcyc);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.v   = exp_v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic press(input int idx, input int hold);
    raw[idx] = 1'b1;
    tick(hold);
    raw[idx] = 1'b0;
    tick(12);
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  initial begin
    logic [6:0] last;
    logic [6:0] cur;
    exp_t       e;
    last = 7'bx;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      cur = outs;
      if (cur !== last) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %b at cyc %0d, none expected", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d", e.nm, cur, cyc, e.v, e.cyc);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    exp_t e;
    rst_n        = 1'b1;
    raw          = 5'b10000;
    u_if.done_i  = 1'b0;
    u_if.error_i = 1'b0;
    exp_v        = 7'b0010000;
    push("reset", 0);
    #3  rst_n = 1'b0;
    #19 rst_n = 1'b1;
    tick(2);

    exp_v[0] = 1'b1; exp_v[5] = 1'b1; push("start_run", 7);
    press(0, 10);

    exp_v[3] = 1'b1; push("pause_on", 7);
    press(3, 10);

    u_if.error_i = 1'b1; exp_v[3] = 1'b0; push("error_clr_pause", 1);
    tick(3);
    press(3, 10);
    u_if.error_i = 1'b0;
    tick(2);

    u_if.done_i = 1'b1; exp_v[0] = 1'b0; exp_v[5] = 1'b0; push("done1", 1);
    tick(3);

    raw[2] = 1'b1; tick(3); raw[2] = 1'b0; tick(10);
    exp_v[2] = 1'b1; push("dry_sel", 7);
    press(2, 10);

    exp_v[0] = 1'b1; exp_v[5] = 1'b1; push("start_rearm", 7);
    raw[0] = 1'b1;
    tick(10);
    u_if.done_i = 1'b0;
    raw[0] = 1'b0;
    tick(12);

    press(2, 10);

    u_if.done_i = 1'b1; exp_v[0] = 1'b0; exp_v[5] = 1'b0; push("done2", 1);
    tick(3);
    u_if.done_i = 1'b0;
    tick(2);

    exp_v[1] = 1'b1; push("dbl_sel", 7);
    press(1, 10);

    raw[4] = 1'b0; exp_v[4] = 1'b0; push("door_open", 6);
    tick(12);

    exp_v[6] = 1'b1; push("reject_on", 7);
    exp_v[6] = 1'b0; push("reject_off", 8);
    press(0, 10);

    raw[4] = 1'b1; exp_v[4] = 1'b1; push("door_close", 6);
    tick(12);

    exp_v[0] = 1'b1; exp_v[5] = 1'b1; push("start_run3", 7);
    press(0, 10);

    exp_v = 7'b0010000; push("async_rst", 0);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    exp_v[2] = 1'b1; push("dry_after_rst", 7);
    press(2, 10);
    tick(10);

    while (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no output change seen, want %b at cyc %0d", e.nm, e.v, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
- Front-panel input stage directly upstream of the washing-machine controller FSM; drives its start, double_wash, dry_wash, time_pause and door_closed inputs.
- Synchronises and debounces raw push-buttons and the door switch, latches program options, toggles pause, and holds start as a level for the duration of a cycle.
- Consumes the controller's done and error_signal to end a cycle and force pause off.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required before a debounced level changes (>=1).
- DB_CNT_W, 8, debounce counter width; must hold DEBOUNCE_CYCLES.
- LOCK_HOLD_CYCLES, 16, start-button hold time that toggles child lock (feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_start_raw  in  1  start button, active-high, asynchronous, bouncy
- btn_double_raw  in  1  double-wash select button
- btn_dry_raw  in  1  dry-wash select button
- btn_pause_raw  in  1  pause button
- door_raw  in  1  door switch, 1 = closed
- done_i  in  1  controller done
- error_i  in  1  controller error_signal
- start_o  out  1  to controller start
- double_wash_o  out  1  to controller double_wash
- dry_wash_o  out  1  to controller dry_wash
- time_pause_o  out  1  to controller time_pause
- door_closed_o  out  1  to controller door_closed
- running_o  out  1  panel in P_RUN
- reject_o  out  1  one-cycle pulse: start press refused

Behaviour:
- Reset is asynchronous on rst_n low; clk and rst_n only.
- Reset values: start_o, double_wash_o, dry_wash_o, time_pause_o, running_o and reject_o are 0. door_closed_o is 1. All debounced levels equal 0 except door, which equals 1. State is P_SELECT.
- Each raw input passes through a 2-flop synchroniser, then a debouncer.
- Debouncer: counter increments while the synchronised sample differs from the debounced level, and clears to 0 otherwise. When the count reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
- A press pulse is a 1-cycle rising edge of the debounced level.
- Latency: raw change to debounced level = 2 + DEBOUNCE_CYCLES edges. Registered FSM outputs respond 1 edge later.
- door_closed_o = debounced door level, in every state.
- FSM states: P_SELECT, P_RUN, P_DONE.
- P_SELECT / P_DONE:
  - double press toggles double_wash_o; dry press toggles dry_wash_o.
  - pause press is ignored; time_pause_o = 0.
  - start press with door_closed_o=1: go to P_RUN, start_o=1, running_o=1.
  - start press with door_closed_o=0: stay, reject_o=1 for one cycle.
- P_RUN:
  - start_o held 1; double_wash_o and dry_wash_o frozen; double, dry and start presses ignored.
  - pause press toggles time_pause_o.
  - error_i=1 forces time_pause_o=0 and ignores pause presses; the state is kept.
  - Rising edge of done_i (done_i=1 and registered done_i=0) goes to P_DONE: start_o=0, time_pause_o=0, running_o=0.
  - A level-high done_i without an edge is ignored. This covers the cycle(s) after re-arming from P_DONE, while the controller has not yet cleared done.
- Simultaneous press pulses in the same cycle: start has priority. The others are processed in the same cycle only if legal in the current state before the transition.
- Reset mid-cycle drops start_o immediately (asynchronous).

Optional Feature:
- PANEL_CHILD_LOCK_EN defined:
  - Debounced start held for LOCK_HOLD_CYCLES consecutive cycles toggles a lock flag, reset 0. The press that triggers the toggle does not act as a start press.
  - While locked, all press pulses except pause are ignored.
  - Adds output locked_o, reset 0.
- Undefined: no lock logic, no locked_o, and start acts on the press edge only.

Decomposition:
- Package wash_panel_pkg: state enum (P_SELECT, P_RUN, P_DONE) and DEBOUNCE_CYCLES default.
- One sub-module, wash_panel_debounce (synchroniser + debouncer + press pulse, parameterised reset level). Instantiate it 5 times.

Test Plan:
- Reset, then btn_start_raw held 1 with door closed and DEBOUNCE_CYCLES=4 -> start_o=1 and running_o=1 at the 7th rising edge; all options 0.
- btn_dry_raw glitches high for 3 cycles, then a clean 10-cycle press -> no toggle from the glitch; dry_wash_o=1 after the clean press; a later dry press in P_RUN leaves it 1.
- door_raw=0 stable, start pressed in P_SELECT -> reject_o pulses exactly 1 cycle; start_o stays 0.
- In P_RUN, press pause -> time_pause_o=1; assert error_i -> time_pause_o=0 next edge; pause press during error -> no change.
- In P_RUN, done_i rises -> start_o=0 next edge, state P_DONE. Press start with done_i held 1 for 3 more cycles -> state stays P_RUN; a second done_i rise later returns to P_DONE.
- Assert rst_n=0 mid-P_RUN -> start_o=0 without waiting for a clk edge, and state is P_SELECT after release.
